seq_alu: RTL and testbench
==========================

Name: seq_alu

Overview:
Parametrised multi-cycle successor to the combinational 16-bit ALU. Executes the same opcode family on WIDTH-bit operands behind a start/busy/done handshake. Logic, add/sub and shift ops complete in one cycle. MUL (shift-add) and DIV (restoring) are iterative, which removes the wide combinational multiplier/divider from the datapath critical path. Sits between register-file read and writeback; full product/remainder returned on hi.

Parameters:
WIDTH, 16, operand/result width (>=4, power of two)
SHW, $clog2(WIDTH), shift-amount bits taken from B (derived, not overridden)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request; sampled only when busy=0
ins  input  4  opcode, sampled with start
A  input  WIDTH  operand A, sampled with start
B  input  WIDTH  operand B, sampled with start
busy  output  1  high while an accepted op is in flight
done  output  1  one-cycle pulse: out/hi/flags updated this cycle
out  output  WIDTH  result (low word / quotient)
hi  output  WIDTH  MUL high word / DIV remainder, else 0
flags  output  3  {carry_err, neg, zero}

Behaviour:
- Reset (async, any state incl. mid-MUL/DIV): state=IDLE; out, hi, flags, busy, done=0; iteration counter and shadow operands cleared. No done pulse is produced for an aborted op.
- Opcodes: 0 NOP (out=0), 1 ADD, 2 SUB (A-B), 3 MUL unsigned, 4 DIV unsigned, 5 AND, 6 OR, 7 XOR, 8 NOT A, 9 SHL A by B[SHW-1:0], 10 SHR logical, 11 SRA, 12-15 reserved.
- FSM states: IDLE, RUN.
  - IDLE + start + single-cycle op: results registered on the sampling edge; done=1 the following cycle; remain IDLE.
  - IDLE + start + MUL/DIV: latch A, B and op; counter=WIDTH; go to RUN; busy=1.
  - RUN: one shift-add or restore-subtract step per clock; counter decrements.
  - Counter 1->0: write results, pulse done, go to IDLE.
- Latency: done after 1 edge for single-cycle ops and WIDTH+1 edges for MUL/DIV, counted from the edge that samples start. busy=1 for exactly WIDTH cycles on MUL/DIV and is never asserted for single-cycle ops.
- start while busy=1: ignored; the in-flight op is unaffected.
- start in the cycle done=1: accepted (state is IDLE), so back-to-back single-cycle ops yield one done per cycle.
- Outputs hold their values between done pulses. NOP still pulses done.
- flags are evaluated on the final out value:
  - zero = (out==0)
  - neg = out[WIDTH-1]
  - carry_err:
    - ADD: carry out of the MSB
    - SUB: borrow (A<B unsigned)
    - MUL: hi!=0
    - DIV: B==0
    - reserved op: 1
    - all other ops: 0
- hi: MUL = product[2W-1:W]; DIV = remainder; all other ops = 0.
- DIV by zero: still takes WIDTH+1 edges; out = all ones, hi = A, carry_err = 1.
- Reserved op: single-cycle; out=0, hi=0, flags=3'b101.
- ADD/SUB wrap modulo 2^WIDTH. Shift amounts >= WIDTH cannot occur because only SHW bits of B are used.

Test Plan:
- WIDTH=16, A=3, B=511, ins=1 -> out=514, hi=0, flags=000; done one cycle after the start edge, busy stays 0.
- Same operands, ins=2 -> out=16'hFE04 (-508), flags=110; ins=9 (shift 511&15=15) -> out=16'h8000, flags=010.
- A=3, B=511, ins=3 -> busy high 16 cycles, done at edge 17, out=1533, hi=0, flags=000. Then A=16'hFFFF, B=16'hFFFF -> out=16'h0001, hi=16'hFFFE, flags=100.
- A=511, B=3, ins=4 -> out=170, hi=1, flags=000. B=0 -> out=16'hFFFF, hi=511, flags=110, latency 17.
- MUL in flight with a second start (ins=1) pulsed at cycle 5 -> ignored; a single done at edge 17 with the MUL result. Then ins=12 -> out=0, flags=101.
- Assert rst at cycle 8 of a DIV -> out/hi/flags/busy/done=0 immediately (asynchronously), no done pulse. After release, a fresh ADD 3+511 returns 514 with done.

Source files
------------

// File: rtl/seq_alu_if.sv
// ---------------------------------------------------------------------------
// seq_alu_if
// Request/response bundle for the sequential ALU.
//   start  requester -> ALU  request, sampled only while busy=0
//   ins    requester -> ALU  opcode, sampled with start
//   A, B   requester -> ALU  operands, sampled with start
//   busy   ALU -> requester  multi-cycle op in flight
//   done   ALU -> requester  one-cycle pulse, out/hi/flags updated
//   out    ALU -> requester  result low word / quotient
//   hi     ALU -> requester  MUL high word / DIV remainder, else 0
//   flags  ALU -> requester  {carry_err, neg, zero}
// ---------------------------------------------------------------------------
interface seq_alu_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [3:0]       ins;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] out;
    logic [WIDTH-1:0] hi;
    logic [2:0]       flags;

    modport master (
        output start, ins, A, B,
        input  busy, done, out, hi, flags
    );

    modport slave (
        input  start, ins, A, B,
        output busy, done, out, hi, flags
    );
endinterface

// File: rtl/seq_alu.sv
// ---------------------------------------------------------------------------
// seq_alu
// Multi-cycle ALU. Logic, add/sub and shift ops finish on the sampling edge;
// MUL (shift-add) and DIV (restoring) iterate one bit per clock for WIDTH
// clocks so no wide multiplier/divider sits in the combinational path.
//   clk  rising-edge clock
//   rst  asynchronous active-high reset; aborts any op without a done pulse
//   bus  seq_alu_if slave: start/ins/A/B in, busy/done/out/hi/flags out
// ---------------------------------------------------------------------------
module seq_alu #(
    parameter int WIDTH = 16
) (
    input  logic      clk,
    input  logic      rst,
    seq_alu_if.slave  bus
);
    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = SHW + 1;          // counter must hold WIDTH itself

    typedef enum logic [3:0] {
        OP_NOP = 4'd0,  OP_ADD = 4'd1,  OP_SUB = 4'd2,  OP_MUL = 4'd3,
        OP_DIV = 4'd4,  OP_AND = 4'd5,  OP_OR  = 4'd6,  OP_XOR = 4'd7,
        OP_NOT = 4'd8,  OP_SHL = 4'd9,  OP_SHR = 4'd10, OP_SRA = 4'd11
    } op_e;

    typedef enum logic {IDLE, RUN} state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             div_q, div_d;        // 1: DIV in flight, 0: MUL
    logic [WIDTH-1:0] b_q, b_d;            // shadow divisor / multiplicand
    logic [WIDTH-1:0] acc_q, acc_d;        // partial product high / remainder
    logic [WIDTH-1:0] lo_q, lo_d;          // multiplier bits / dividend->quotient
    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [2:0]       flags_q, flags_d;
    logic             done_q, done_d;

    // ---------------- single-cycle datapath ----------------
    logic [WIDTH:0]   add_full, sub_full;
    logic [SHW-1:0]   sh;
    logic [WIDTH-1:0] sc_out;
    logic             sc_carry;

    assign add_full = {1'b0, bus.A} + {1'b0, bus.B};
    assign sub_full = {1'b0, bus.A} - {1'b0, bus.B};   // MSB is the borrow
    assign sh       = bus.B[SHW-1:0];

    // NOTE: every always_comb output gets a default first so no path leaves a
    // variable unassigned, which would otherwise infer a latch.
    always_comb begin
        sc_out   = '0;
        sc_carry = 1'b0;
        case (bus.ins)
            OP_NOP, OP_MUL, OP_DIV: ;
            OP_ADD: begin sc_out = add_full[WIDTH-1:0]; sc_carry = add_full[WIDTH]; end
            OP_SUB: begin sc_out = sub_full[WIDTH-1:0]; sc_carry = sub_full[WIDTH]; end
            OP_AND: sc_out = bus.A & bus.B;
            OP_OR:  sc_out = bus.A | bus.B;
            OP_XOR: sc_out = bus.A ^ bus.B;
            OP_NOT: sc_out = ~bus.A;
            OP_SHL: sc_out = bus.A << sh;
            OP_SHR: sc_out = bus.A >> sh;
            OP_SRA: sc_out = $unsigned($signed(bus.A) >>> sh);
            default: sc_carry = 1'b1;      // reserved: out=0, flags=101
        endcase
    end

    // ---------------- iterative step ----------------
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_trial;
    logic             div_ge;
    logic [WIDTH-1:0] div_diff;
    logic [WIDTH-1:0] step_acc, step_lo;
    logic             it_carry;

    assign mul_sum   = {1'b0, acc_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    assign div_trial = {acc_q, lo_q[WIDTH-1]};
    assign div_ge    = div_trial >= {1'b0, b_q};
    // Only used when div_ge, so the true difference fits in WIDTH bits.
    assign div_diff  = div_trial[WIDTH-1:0] - b_q;

    always_comb begin
        step_acc = '0;
        step_lo  = '0;
        it_carry = 1'b0;
        if (div_q) begin
            step_acc = div_ge ? div_diff : div_trial[WIDTH-1:0];
            step_lo  = {lo_q[WIDTH-2:0], div_ge};
            it_carry = (b_q == '0);
        end else begin
            // Right-shifting product: carry of the add lands in the top bit.
            step_acc = mul_sum[WIDTH:1];
            step_lo  = {mul_sum[0], lo_q[WIDTH-1:1]};
            it_carry = (mul_sum[WIDTH:1] != '0);
        end
    end

    // ---------------- FSM next state / outputs ----------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        b_d     = b_q;
        acc_d   = acc_q;
        lo_d    = lo_q;
        out_d   = out_q;
        hi_d    = hi_q;
        flags_d = flags_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bus.ins == OP_MUL || bus.ins == OP_DIV) begin
                        div_d   = (bus.ins == OP_DIV);
                        b_d     = bus.B;
                        acc_d   = '0;
                        lo_d    = bus.A;
                        cnt_d   = CW'(WIDTH);
                        state_d = RUN;
                    end else begin
                        out_d   = sc_out;
                        hi_d    = '0;
                        flags_d = {sc_carry, sc_out[WIDTH-1], sc_out == '0};
                        done_d  = 1'b1;
                    end
                end
            end
            RUN: begin
                acc_d = step_acc;
                lo_d  = step_lo;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    out_d   = step_lo;
                    hi_d    = step_acc;
                    flags_d = {it_carry, step_lo[WIDTH-1], step_lo == '0};
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            div_q   <= 1'b0;
            b_q     <= '0;
            acc_q   <= '0;
            lo_q    <= '0;
            out_q   <= '0;
            hi_q    <= '0;
            flags_q <= '0;
            done_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            lo_q    <= lo_d;
            out_q   <= out_d;
            hi_q    <= hi_d;
            flags_q <= flags_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy  = (state_q == RUN);
    assign bus.done  = done_q;
    assign bus.out   = out_q;
    assign bus.hi    = hi_q;
    assign bus.flags = flags_q;

endmodule

// File: tb/tb_seq_alu.sv
// ---------------------------------------------------------------------------
// tb_seq_alu
// Self-checking bench for seq_alu at WIDTH=16: a table of directed vectors,
// hand-written handshake/reset sequences, and random ops against a
// plain-arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_seq_alu;
    localparam int W = 16;

    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_bad = 0;

    seq_alu_if #(.WIDTH(W)) bus ();

    seq_alu #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]   ins;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] out;
        logic [W-1:0] hi;
        logic [2:0]   flags;
        int           lat;
    } vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference model: results straight from arithmetic definitions.
    task automatic model(input logic [3:0] ins, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] o, output logic [W-1:0] h, output logic [2:0] f);
        longint unsigned ua = a, ub = b, r;
        int sh = int'(b) % W;
        logic c = 1'b0;
        h = '0;
        case (ins)
            4'd0:  o = '0;
            4'd1:  begin r = ua + ub; o = W'(r); c = (r >= 65536); end
            4'd2:  begin o = W'(ua - ub); c = (ua < ub); end
            4'd3:  begin r = ua * ub; o = W'(r); h = W'(r / 65536); c = (h != 0); end
            4'd4:  if (ub == 0) begin o = 16'hFFFF; h = a; c = 1'b1; end
                   else begin o = W'(ua / ub); h = W'(ua % ub); end
            4'd5:  o = a & b;
            4'd6:  o = a | b;
            4'd7:  o = a ^ b;
            4'd8:  o = ~a;
            4'd9:  o = W'(ua * (64'd1 << sh));
            4'd10: o = W'(ua / (64'd1 << sh));
            4'd11: begin
                       int sa = int'($signed(a));
                       o = W'(sa >>> sh);
                   end
            default: begin o = '0; c = 1'b1; end
        endcase
        f = {c, o[W-1], o == 0};
    endtask

    // Issue one op and wait for done. lat counts edges from the sampling edge.
    task automatic do_op(input logic [3:0] ins, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] o, output logic [W-1:0] h, output logic [2:0] f,
                         output int lat, output int busy_cnt);
        @(negedge clk);
        bus.start = 1'b1; bus.ins = ins; bus.A = a; bus.B = b;
        @(posedge clk);
        lat = 1; busy_cnt = 0;
        @(negedge clk);
        bus.start = 1'b0;
        while (!bus.done && lat < 40) begin
            if (bus.busy) busy_cnt++;
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        if (bus.busy) busy_cnt++;
        o = bus.out; h = bus.hi; f = bus.flags;
    endtask

    vec_t vecs[15];

    initial begin
        logic [W-1:0] o, h, eo, eh;
        logic [2:0]   f, ef;
        int           lat, bc, ndone, first_done;

        bus.start = 1'b0; bus.ins = '0; bus.A = '0; bus.B = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_out", bus.out, 0);
        check("reset_hi", bus.hi, 0);
        check("reset_flags", bus.flags, 0);
        check("reset_busy_done", {bus.busy, bus.done}, 0);
        rst = 1'b0;

        vecs[0]  = '{4'd1,  16'd3,      16'd511,    16'd514,    16'd0,      3'b000, 1};
        vecs[1]  = '{4'd2,  16'd3,      16'd511,    16'hFE04,   16'd0,      3'b110, 1};
        vecs[2]  = '{4'd9,  16'd3,      16'd511,    16'h8000,   16'd0,      3'b010, 1};
        vecs[3]  = '{4'd3,  16'd3,      16'd511,    16'd1533,   16'd0,      3'b000, 17};
        vecs[4]  = '{4'd3,  16'hFFFF,   16'hFFFF,   16'h0001,   16'hFFFE,   3'b100, 17};
        vecs[5]  = '{4'd4,  16'd511,    16'd3,      16'd170,    16'd1,      3'b000, 17};
        vecs[6]  = '{4'd4,  16'd511,    16'd0,      16'hFFFF,   16'd511,    3'b110, 17};
        vecs[7]  = '{4'd12, 16'd3,      16'd511,    16'd0,      16'd0,      3'b101, 1};
        vecs[8]  = '{4'd0,  16'd3,      16'd511,    16'd0,      16'd0,      3'b001, 1};
        vecs[9]  = '{4'd11, 16'h8000,   16'd4,      16'hF800,   16'd0,      3'b010, 1};
        vecs[10] = '{4'd10, 16'h8000,   16'd4,      16'h0800,   16'd0,      3'b000, 1};
        vecs[11] = '{4'd1,  16'hFFFF,   16'd1,      16'd0,      16'd0,      3'b101, 1};
        vecs[12] = '{4'd8,  16'h0000,   16'h1234,   16'hFFFF,   16'd0,      3'b010, 1};
        vecs[13] = '{4'd7,  16'hAAAA,   16'hAAAA,   16'd0,      16'd0,      3'b001, 1};
        vecs[14] = '{4'd15, 16'hFFFF,   16'hFFFF,   16'd0,      16'd0,      3'b101, 1};

        for (int i = 0; i < 15; i++) begin
            do_op(vecs[i].ins, vecs[i].a, vecs[i].b, o, h, f, lat, bc);
            check($sformatf("vec%0d_out", i), o, vecs[i].out);
            check($sformatf("vec%0d_hi", i), h, vecs[i].hi);
            check($sformatf("vec%0d_flags", i), f, vecs[i].flags);
            check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
            check($sformatf("vec%0d_busy_cycles", i), bc, (vecs[i].lat == 17) ? 16 : 0);
        end

        // MUL in flight; a second start pulsed at cycle 5 must be ignored.
        @(negedge clk);
        bus.start = 1'b1; bus.ins = 4'd3; bus.A = 16'd3; bus.B = 16'd511;
        @(posedge clk);
        lat = 1; ndone = 0; first_done = 0;
        for (int c = 1; c <= 22; c++) begin
            @(negedge clk);
            bus.start = (c == 4);
            if (c == 4) begin bus.ins = 4'd1; bus.A = 16'd1; bus.B = 16'd1; end
            if (bus.done) begin
                ndone++;
                if (first_done == 0) begin
                    first_done = c;
                    check("ignored_start_out", bus.out, 1533);
                end
            end
            @(posedge clk);
        end
        check("ignored_start_done_count", ndone, 1);
        check("ignored_start_done_edge", first_done, 17);

        // Back-to-back single-cycle ops: one done per cycle, outputs then hold.
        @(negedge clk);
        bus.start = 1'b1; bus.ins = 4'd1; bus.A = 16'd3; bus.B = 16'd511;
        @(posedge clk);
        @(negedge clk);
        check("b2b_first_done", bus.done, 1);
        check("b2b_first_out", bus.out, 514);
        bus.ins = 4'd2;
        @(posedge clk);
        @(negedge clk);
        check("b2b_second_done", bus.done, 1);
        check("b2b_second_out", bus.out, 16'hFE04);
        bus.start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("b2b_done_drops", bus.done, 0);
        check("b2b_out_holds", bus.out, 16'hFE04);

        // Asynchronous reset in cycle 8 of a DIV.
        @(negedge clk);
        bus.start = 1'b1; bus.ins = 4'd4; bus.A = 16'd511; bus.B = 16'd3;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (7) @(negedge clk);
        check("abort_busy_before", bus.busy, 1);
        rst = 1'b1;
        #1;
        check("abort_out", bus.out, 0);
        check("abort_hi", bus.hi, 0);
        check("abort_flags", bus.flags, 0);
        check("abort_busy_done", {bus.busy, bus.done}, 0);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.done || bus.busy) ndone++;
        end
        check("abort_no_done", ndone, 0);
        do_op(4'd1, 16'd3, 16'd511, o, h, f, lat, bc);
        check("after_abort_out", o, 514);
        check("after_abort_latency", lat, 1);

        // Random ops against the reference model; bias B toward small/zero.
        for (int i = 0; i < 200; i++) begin
            logic [3:0]   ins;
            logic [W-1:0] a, b;
            ins = 4'($urandom_range(0, 15));
            a   = W'($urandom);
            case ($urandom_range(0, 3))
                0:       b = '0;
                1:       b = W'($urandom_range(1, 20));
                default: b = W'($urandom);
            endcase
            model(ins, a, b, eo, eh, ef);
            do_op(ins, a, b, o, h, f, lat, bc);
            check($sformatf("rnd%0d_op%0d_out", i, ins), o, eo);
            check($sformatf("rnd%0d_op%0d_hi", i, ins), h, eh);
            check($sformatf("rnd%0d_op%0d_flags", i, ins), f, ef);
            check($sformatf("rnd%0d_op%0d_latency", i, ins), lat, (ins == 3 || ins == 4) ? 17 : 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
